// File: rtl/phase_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : phase_sequencer_pkg
//  Purpose  : Constants shared by the phase sequencer and the control decoder.
//             This covers the phase numbers, the sequencer state encodings and
//             the HLT opcode fields, plus a helper that recognises HLT.
//  Revision : 1.0 - initial release
// ============================================================================
package phase_sequencer_pkg;

   // Phase numbers as seen by the control decoder (0 = idle, gates all off)
   localparam logic [2:0] PH_IDLE = 3'd0;
   localparam logic [2:0] PH_1    = 3'd1;
   localparam logic [2:0] PH_2    = 3'd2;
   localparam logic [2:0] PH_3    = 3'd3;
   localparam logic [2:0] PH_4    = 3'd4;
   localparam logic [2:0] PH_5    = 3'd5;

   // Sequencer state encodings
   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_RUN       = 2'd1;
   localparam logic [1:0] ST_STEP_WAIT = 2'd2;
   localparam logic [1:0] ST_HALTED    = 2'd3;

   // Instruction fields shared with the control decoder
   localparam logic [1:0] OP_ALU  = 2'b11;
   localparam logic [3:0] ALU_HLT = 4'b1111;

   // HLT is an ALU-class instruction carrying the all-ones ALU sub-op
   function automatic logic is_hlt(input logic [1:0] op, input logic [3:0] alu_op);
      return (op == OP_ALU) && (alu_op == ALU_HLT);
   endfunction

endpackage
`default_nettype wire

// File: rtl/phase_sequencer_rise_pulse.sv
`default_nettype none
// ============================================================================
//  Module   : rise_pulse
//  Purpose  : One-cycle pulse on a rising edge of a level input.
//  Ports    : clk - system clock, rising edge
//             rst - asynchronous active-high reset
//             d   - level input (already debounced/synchronous)
//             p   - pulse, high for the cycle in which d first reads 1
//  Revision : 1.0 - initial release
// ============================================================================
module rise_pulse (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic p
);

   logic r_d;
   logic r_armed;

   // r_armed stays low for the first cycle after reset. A level that was
   // held high through reset is therefore absorbed into r_d without ever
   // being mistaken for a fresh edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_d     <= 1'b0;
         r_armed <= 1'b0;
      end else begin
         r_d     <= d;
         r_armed <= 1'b1;
      end
   end

   assign p = d & ~r_d & r_armed;

endmodule
`default_nettype wire

// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : phase_sequencer
//  Purpose  : Generates the 3-bit execution phase for the control decoder.
//             Supports run, halt and single-step operation, honours stall,
//             detects HLT, and counts retired instructions.
//  Ports    : clk         - system clock, rising edge
//             rst         - asynchronous active-high reset
//             start       - run request (rising edge acts)
//             step_mode   - 1 = pause in phase 0 after each instruction
//             step        - advance one instruction in step mode (rising edge)
//             stall       - hold the current phase
//             instruction - current IR (op=[15:14], alu_op=[7:4])
//             phase       - current phase, 0 = idle, 1..NUM_PHASES active
//             running     - 1 in RUN state
//             halted      - 1 in HALTED state
//             instr_count - instructions retired since reset
//  Revision : 1.0 - initial release
// ============================================================================
module phase_sequencer
   import phase_sequencer_pkg::*;
#(
   parameter int NUM_PHASES = 5,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             step_mode,
   input  logic             step,
   input  logic             stall,
   input  logic [15:0]      instruction,
   output logic [2:0]       phase,
   output logic             running,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   localparam logic [2:0] c_last_phase = 3'(NUM_PHASES);

   logic             w_start_p;
   logic             w_step_p;
   logic             w_hlt;
   logic             w_unused_ir;

   logic [1:0]       r_state;
   logic [2:0]       r_phase;
   logic [CNT_W-1:0] r_count;
   logic             r_running;
   logic             r_halted;

   logic [1:0]       w_state_nxt;
   logic [2:0]       w_phase_nxt;
   logic [CNT_W-1:0] w_count_nxt;

   rise_pulse u_start_pulse (
      .clk (clk),
      .rst (rst),
      .d   (start),
      .p   (w_start_p)
   );

   rise_pulse u_step_pulse (
      .clk (clk),
      .rst (rst),
      .d   (step),
      .p   (w_step_p)
   );

   assign w_hlt       = is_hlt(instruction[15:14], instruction[7:4]);
   // The remaining IR bits are the decoder's business, not ours
   assign w_unused_ir = ^{instruction[13:8], instruction[3:0]};

   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_count_nxt = r_count;

      case (r_state)
         ST_IDLE: begin
            w_phase_nxt = PH_IDLE;
            if (w_start_p) begin
               w_state_nxt = ST_RUN;
               w_phase_nxt = PH_1;
            end
         end

         ST_RUN: begin
            if (!stall) begin
               // HLT is checked before the last-phase test so that it is
               // never counted, even in a two-phase configuration.
               if ((r_phase == PH_2) && w_hlt) begin
                  w_state_nxt = ST_HALTED;
                  w_phase_nxt = PH_IDLE;
               end else if (r_phase < c_last_phase) begin
                  w_phase_nxt = r_phase + 3'd1;
               end else begin
                  w_count_nxt = r_count + CNT_W'(1);
                  // step_mode is looked at only here, at the instruction
                  // boundary, so a mid-instruction change cannot split it.
                  if (step_mode) begin
                     w_state_nxt = ST_STEP_WAIT;
                     w_phase_nxt = PH_IDLE;
                  end else begin
                     w_phase_nxt = PH_1;
                  end
               end
            end
         end

         ST_STEP_WAIT: begin
            w_phase_nxt = PH_IDLE;
            if (w_step_p || (w_start_p && !step_mode)) begin
               w_state_nxt = ST_RUN;
               w_phase_nxt = PH_1;
            end
         end

         ST_HALTED: begin
            w_phase_nxt = PH_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_phase_nxt = PH_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_phase   <= PH_IDLE;
         r_count   <= '0;
         r_running <= 1'b0;
         r_halted  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_phase   <= w_phase_nxt;
         r_count   <= w_count_nxt;
         r_running <= (w_state_nxt == ST_RUN);
         r_halted  <= (w_state_nxt == ST_HALTED);
      end
   end

   assign phase       = r_phase;
   assign running     = r_running;
   assign halted      = r_halted;
   assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phase_sequencer
//  Purpose  : Directed self-checking bench for phase_sequencer. A 16-bit
//             counter instance exercises run/stall/halt/step/reset, and a
//             4-bit counter instance exercises counter wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_phase_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        step_mode = 1'b0;
   logic        step = 1'b0;
   logic        stall = 1'b0;
   logic [15:0] instruction = 16'h0010;
   logic [2:0]  phase;
   logic        running;
   logic        halted;
   logic [15:0] instr_count;

   logic        start4 = 1'b0;
   logic [2:0]  phase4;
   logic        running4;
   logic        halted4;
   logic [3:0]  count4;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [15:0] c_add = 16'h0010;
   localparam logic [15:0] c_hlt = 16'hC0F0;

   phase_sequencer #(.NUM_PHASES(5), .CNT_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .step_mode   (step_mode),
      .step        (step),
      .stall       (stall),
      .instruction (instruction),
      .phase       (phase),
      .running     (running),
      .halted      (halted),
      .instr_count (instr_count)
   );

   phase_sequencer #(.NUM_PHASES(5), .CNT_W(4)) dut4 (
      .clk         (clk),
      .rst         (rst),
      .start       (start4),
      .step_mode   (1'b0),
      .step        (1'b0),
      .stall       (1'b0),
      .instruction (c_add),
      .phase       (phase4),
      .running     (running4),
      .halted      (halted4),
      .instr_count (count4)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_cmp++;
      assert (obs === req)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, req);
      end
   endtask

   // Packed as {phase, running, halted, instr_count}
   task automatic st(input string tag, input logic [2:0] ph, input logic run,
                     input logic hlt, input logic [15:0] cnt);
      chk(tag, {11'd0, phase, running, halted, instr_count},
               {11'd0, ph, run, hlt, cnt});
   endtask

   initial begin
      // Reset state
      tick;
      tick;
      st("reset", 3'd0, 1'b0, 1'b0, 16'd0);
      chk("reset4", {25'd0, phase4, running4, halted4, count4}, 32'd0);
      rst = 1'b0;
      tick;

      // 1: start, one full sweep, count increments on wrap
      start = 1'b1;
      tick;
      st("t1_p1", 3'd1, 1'b1, 1'b0, 16'd0);
      start = 1'b0;
      for (int p = 2; p <= 5; p++) begin
         tick;
         st("t1_sweep", 3'(p), 1'b1, 1'b0, 16'd0);
      end
      tick;
      st("t1_wrap", 3'd1, 1'b1, 1'b0, 16'd1);
      tick;
      tick;
      st("t1_p3", 3'd3, 1'b1, 1'b0, 16'd1);

      // 2: stall three cycles in phase 3
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         st("t2_stall", 3'd3, 1'b1, 1'b0, 16'd1);
      end
      stall = 1'b0;
      tick;
      st("t2_p4", 3'd4, 1'b1, 1'b0, 16'd1);
      tick;
      st("t2_p5", 3'd5, 1'b1, 1'b0, 16'd1);
      tick;
      st("t2_done", 3'd1, 1'b1, 1'b0, 16'd2);

      // 3: HLT, deferred by stall in phase 2, then start/step ignored
      instruction = c_hlt;
      tick;
      st("t3_p2", 3'd2, 1'b1, 1'b0, 16'd2);
      stall = 1'b1;
      tick;
      st("t3_defer", 3'd2, 1'b1, 1'b0, 16'd2);
      stall = 1'b0;
      tick;
      st("t3_halt", 3'd0, 1'b0, 1'b1, 16'd2);
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      start = 1'b1;
      step  = 1'b1;
      tick;
      st("t3_ignore", 3'd0, 1'b0, 1'b1, 16'd2);
      start = 1'b0;
      step  = 1'b0;

      // Asynchronous reset out of HALTED, checked before the next edge
      rst = 1'b1;
      #1;
      st("t_rst_async", 3'd0, 1'b0, 1'b0, 16'd0);
      tick;
      rst = 1'b0;
      instruction = c_add;
      step_mode = 1'b1;
      tick;

      // 4: single-step
      start = 1'b1;
      tick;
      st("t4_p1", 3'd1, 1'b1, 1'b0, 16'd0);
      start = 1'b0;
      for (int p = 2; p <= 5; p++) tick;
      st("t4_p5", 3'd5, 1'b1, 1'b0, 16'd0);
      tick;
      st("t4_wait", 3'd0, 1'b0, 1'b0, 16'd1);
      stall = 1'b1;
      tick;
      st("t4_wait_stall", 3'd0, 1'b0, 1'b0, 16'd1);
      stall = 1'b0;
      step = 1'b1;
      tick;
      st("t4_step1", 3'd1, 1'b1, 1'b0, 16'd1);
      for (int p = 2; p <= 5; p++) begin
         tick;
         st("t4_step_sweep", 3'(p), 1'b1, 1'b0, 16'd1);
      end
      tick;
      st("t4_wait2", 3'd0, 1'b0, 1'b0, 16'd2);
      step = 1'b0;
      tick;
      start = 1'b1;
      step  = 1'b1;
      tick;
      st("t4_both_p1", 3'd1, 1'b1, 1'b0, 16'd2);
      tick;
      st("t4_both_once", 3'd2, 1'b1, 1'b0, 16'd2);
      start = 1'b0;
      step  = 1'b0;
      for (int p = 3; p <= 5; p++) tick;
      tick;
      st("t4_wait3", 3'd0, 1'b0, 1'b0, 16'd3);
      step_mode = 1'b0;
      tick;
      tick;
      st("t4_modefall", 3'd0, 1'b0, 1'b0, 16'd3);
      start = 1'b1;
      tick;
      st("t4_resume", 3'd1, 1'b1, 1'b0, 16'd3);
      start = 1'b0;
      tick;
      tick;
      tick;
      st("t5_p4", 3'd4, 1'b1, 1'b0, 16'd3);

      // 5: async reset mid phase 4 with start held high
      start = 1'b1;
      rst   = 1'b1;
      #1;
      st("t5_async", 3'd0, 1'b0, 1'b0, 16'd0);
      tick;
      rst = 1'b0;
      tick;
      tick;
      st("t5_no_run", 3'd0, 1'b0, 1'b0, 16'd0);
      start = 1'b0;
      tick;
      start = 1'b1;
      tick;
      st("t5_retoggle", 3'd1, 1'b1, 1'b0, 16'd0);
      start = 1'b0;

      // 6: 4-bit counter wraps 15 -> 0
      start4 = 1'b1;
      tick;
      chk("t6_p1", {29'd0, phase4}, 32'd1);
      start4 = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         repeat (5) tick;
         chk("t6_count", {28'd0, count4}, {28'd0, 4'(i)});
      end
      chk("t6_phase", {29'd0, phase4}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
